// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family.
//   - FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter
//   - clog2                : constant ceiling-log2 for parameter arithmetic
//   - *_ok functions       : parameter legality predicates, evaluated at
//                            elaboration by the FIFO tops
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Almost-full threshold must lie in 1..DEPTH.
  function automatic bit afull_thresh_ok(input int asize, input int thresh);
    return (thresh >= 1) && (thresh <= (1 << asize));
  endfunction

  // Almost-empty threshold must lie in 0..DEPTH-1.
  function automatic bit aempty_thresh_ok(input int asize, input int thresh);
    return (thresh >= 0) && (thresh <= (1 << asize) - 1);
  endfunction

  function automatic bit fwft_mode_ok(input int mode);
    return (mode == FIFO_STD) || (mode == FIFO_FWFT);
  endfunction

endpackage

// File: rtl/fifomemory.sv
// Dual-port FIFO storage: synchronous write, combinational read.
// Ports:
//   wclk   - write clock
//   wclken - write enable (already qualified by the caller)
//   waddr  - write address
//   raddr  - read address
//   wdata  - write data
//   rdata  - read data, combinational from raddr
module fifomemory #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wclken,
  input  logic [ASIZE-1:0] waddr,
  input  logic [ASIZE-1:0] raddr,
  input  logic [DSIZE-1:0] wdata,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  // NOTE: storage array has no reset; the pointers alone decide which
  // words are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge wclk) begin
    if (wclken) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with exact fill level, almost-full/almost-empty
// thresholds, selectable standard or first-word-fall-through read, and
// sticky overflow/underflow flags.
// Ports:
//   clk, rst       - clock; asynchronous active-high reset
//   wdata, winc    - write data and write request
//   rinc           - read request (FWFT: pop head word)
//   err_clr        - clears overflow and underflow
//   rdata          - read data (registered, or head word in FWFT)
//   wfull, rempty  - level == DEPTH / level == 0
//   walmost_full   - level >= AFULL_THRESH
//   ralmost_empty  - level <= AEMPTY_THRESH
//   level          - stored word count, 0..DEPTH
//   overflow       - sticky: a write was rejected
//   underflow      - sticky: a read was rejected
module sync_fifo_level
  import fifo_pkg::*;
#(
  parameter int DSIZE         = 8,
  parameter int ASIZE         = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_L  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_L  = (ASIZE+1)'(AFULL_THRESH);
  localparam logic [ASIZE:0] AEMPTY_L = (ASIZE+1)'(AEMPTY_THRESH);

  if (clog2(DEPTH) != ASIZE || ASIZE < 1) begin : g_bad_asize
    $error("sync_fifo_level: ASIZE must be at least 1");
  end
  if (!afull_thresh_ok(ASIZE, AFULL_THRESH)) begin : g_bad_afull
    $error("sync_fifo_level: AFULL_THRESH outside 1..DEPTH");
  end
  if (!aempty_thresh_ok(ASIZE, AEMPTY_THRESH)) begin : g_bad_aempty
    $error("sync_fifo_level: AEMPTY_THRESH outside 0..DEPTH-1");
  end
  if (!fwft_mode_ok(FWFT)) begin : g_bad_fwft
    $error("sync_fifo_level: FWFT must be FIFO_STD or FIFO_FWFT");
  end

  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [DSIZE-1:0] mem_rdata;
  logic             wacc;
  logic             racc;

  // Modulo subtraction stays correct across pointer wrap.
  assign level         = wptr - rptr;
  assign wfull         = (level == DEPTH_L);
  assign rempty        = (level == '0);
  assign walmost_full  = (level >= AFULL_L);
  assign ralmost_empty = (level <= AEMPTY_L);

  // Acceptance uses the flags as registered at the start of the cycle, so a
  // simultaneous read never frees space for the write (full) and a
  // simultaneous write never feeds the read (empty).
  assign wacc = winc && !wfull;
  assign racc = rinc && !rempty;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wacc) wptr <= wptr + 1'b1;
      if (racc) rptr <= rptr + 1'b1;
    end
  end

  // A new error in the same cycle as err_clr takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (winc && wfull)  || (overflow  && !err_clr);
      underflow <= (rinc && rempty) || (underflow && !err_clr);
    end
  end

  fifomemory #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .wclk   (clk),
    .wclken (wacc),
    .waddr  (wptr[ASIZE-1:0]),
    .raddr  (rptr[ASIZE-1:0]),
    .wdata  (wdata),
    .rdata  (mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Head word is always presented; meaningless while rempty is high.
    assign rdata = mem_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)       rdata_q <= '0;
      else if (racc) rdata_q <= mem_rdata;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: doc/sync_fifo_level.md
# sync_fifo_level

Single-clock, parametrised FIFO: the next generation of the team's FIFO family for blocks that share one clock domain. On top of full and empty it adds an exact fill level, programmable almost-full and almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It sits between same-clock producers and consumers, and no pointer synchronisers are needed.

## Interface
Parameters:
- DSIZE, 8, data width in bits
- ASIZE, 4, address width; DEPTH = 2^ASIZE words
- AFULL_THRESH, 12, walmost_full asserts when level >= this value (legal range 1..DEPTH)
- AEMPTY_THRESH, 4, ralmost_empty asserts when level <= this value (legal range 0..DEPTH-1)
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through

Ports:
- clk  input  1  the single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- wdata  input  DSIZE  write data
- winc  input  1  write request
- rinc  input  1  read request (in FWFT mode: pop the head word)
- err_clr  input  1  clears overflow and underflow
- rdata  output  DSIZE  read data
- wfull  output  1  level == DEPTH
- rempty  output  1  level == 0
- walmost_full  output  1  level >= AFULL_THRESH
- ralmost_empty  output  1  level <= AEMPTY_THRESH
- level  output  ASIZE+1  number of stored words, 0..DEPTH
- overflow  output  1  sticky; a write was rejected
- underflow  output  1  sticky; a read was rejected

## Operation
- **Pointers.** wptr and rptr are (ASIZE+1)-bit binary; the low ASIZE bits address memory. The MSB disambiguates full from empty. Both wrap modulo 2^(ASIZE+1).
- **Write.** Accepted iff winc && !wfull, using wfull as registered at the start of the cycle. On accept, wdata goes to mem[waddr] and wptr increments.
- **Read.** Accepted iff rinc && !rempty. On accept, rptr increments.
- **Simultaneous read and write:**
  - Neither full nor empty: both are accepted; level is unchanged.
  - Full: the read is accepted and the write is rejected (overflow sets).
  - Empty: the write is accepted and the read is rejected (underflow sets). There is no read-through of the word being written.
- **Level.** level = wptr - rptr, computed modulo 2^(ASIZE+1). All four status flags derive combinationally from the registered level.
- **Error flags.** overflow sets on winc && wfull; underflow sets on rinc && rempty. err_clr clears both. If a set and err_clr occur in the same cycle, the set wins.
- **FWFT = 0.** rdata is a register loaded with mem[raddr] on an accepted read. It holds its value otherwise.
- **FWFT = 1.** rdata = mem[raddr] combinationally, valid whenever !rempty. rinc pops the head word, and rdata then shows the next word in the same cycle after the edge. rdata is don't-care while rempty is high.
- **Reset (async assert, sync release):**
  - wptr = rptr = 0, level = 0
  - rempty = 1, wfull = 0
  - ralmost_empty = 1; walmost_full = 0
  - overflow = underflow = 0
  - registered rdata = 0
  - Memory contents are not reset.
- **Reset mid-operation.** All stored data is discarded immediately. The first write after release lands at address 0.

## Timing
- **Write to visibility:** a write accepted at edge N gives level +1, rempty = 0, and updated almost flags after edge N.
- **FWFT = 0, read latency:** 1 cycle; rinc accepted at edge N gives rdata valid after edge N.
- **FWFT = 1, write-to-data latency:** 1 cycle; a word written into an empty FIFO at edge N is on rdata, with rempty = 0, after edge N.
- **Back-to-back throughput:** one write and one read per cycle, sustained indefinitely.
- **Threshold flags:** registered-level based, so they lag the triggering edge by 0 cycles after that edge. There is no extra pipeline stage.
- **Wrap-around:** after 2^(ASIZE+1) pointer increments, level and flags are unaffected.

## Structure
- Shared package fifo_pkg holds:
  - constant function clog2
  - parameter legality checks, raised as elaboration errors for out-of-range thresholds
  - FWFT mode constants FIFO_STD = 0 and FIFO_FWFT = 1
- One sub-module: fifomemory, the existing dual-port memory with synchronous write and combinational read. Instantiate it with DSIZE and ASIZE.
- Pointer, level, flag, and error logic stay in the top module; no further sub-modules.

## Test plan
- **Fill and drain:** with defaults, reset, then 16 writes of 0x00..0x0F, then 16 reads.
  - walmost_full rises after write 12.
  - wfull and level = 16 after write 16.
  - Reads return 0x00..0x0F in order.
  - ralmost_empty rises when level = 4; rempty = 1 at the end.
- **Overflow and clear:**
  - Write a 17th word (0xAA) while full: overflow = 1, level stays 16, 0xAA is never read.
  - Pulse err_clr: overflow = 0.
  - Assert winc (wfull still set) and err_clr together: overflow = 1.
- **Underflow and simultaneous access:**
  - rinc while empty: underflow = 1.
  - winc and rinc together while empty with wdata 0x55: level = 1, and the next read returns 0x55.
  - At level 8, run 20 cycles of simultaneous winc and rinc: level stays 8 and data order is preserved across pointer wrap.
- **FWFT = 1:**
  - Write 0x3C into an empty FIFO: the next cycle shows rempty = 0 and rdata = 0x3C without rinc.
  - Then write 0x3D and pulse rinc: rdata = 0x3D.
- **Mid-operation reset:**
  - At level 9, assert rst asynchronously between edges: level = 0, rempty = 1, flags at reset values immediately.
  - After release, write 0x11 and read it back as 0x11.
